// File: rtl/window_gen_5x5.sv
// Builds a 5x5 neighbourhood around each interior pixel of a raster stream using 4 line buffers.
// Latency: 1 cycle from acceptance of the bottom-right pixel to the registered window.
// Backpressure: a held window that is not taken drops pix_ready and freezes all state.
module window_gen_5x5 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pix_valid,
    output logic         pix_ready,
    input  logic [7:0]   pix_data,
    output logic         win_valid,
    input  logic         win_ready,
    output logic [199:0] win_data,
    output logic [15:0]  win_x,
    output logic [15:0]  win_y,
    output logic         win_last
);
    localparam int          XW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

    logic [15:0]          x_cnt;
    logic [15:0]          y_cnt;
    logic [XW-1:0]        lb_addr;
    logic                 accept;
    logic                 emit;

    logic [7:0]           lb0 [IMG_WIDTH];
    logic [7:0]           lb1 [IMG_WIDTH];
    logic [7:0]           lb2 [IMG_WIDTH];
    logic [7:0]           lb3 [IMG_WIDTH];
    logic [7:0]           lb0_rd;
    logic [7:0]           lb1_rd;
    logic [7:0]           lb2_rd;
    logic [7:0]           lb3_rd;

    // Packed [row][col][bit] so that (r,c) lands at [(5*r+c)*8 +: 8] when flattened.
    logic [4:0][4:0][7:0] win_q;
    logic [4:0][4:0][7:0] win_nxt;

    assign pix_ready = !win_valid || win_ready;
    assign accept    = pix_valid && pix_ready;
    assign emit      = (x_cnt >= 16'd4) && (y_cnt >= 16'd4);
    assign lb_addr   = x_cnt[XW-1:0];

    assign lb0_rd = lb0[lb_addr];
    assign lb1_rd = lb1[lb_addr];
    assign lb2_rd = lb2[lb_addr];
    assign lb3_rd = lb3[lb_addr];

    always_comb begin
        win_nxt = win_q;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                win_nxt[r][c] = win_q[r][c+1];
            end
        end
        win_nxt[0][4] = lb0_rd;
        win_nxt[1][4] = lb1_rd;
        win_nxt[2][4] = lb2_rd;
        win_nxt[3][4] = lb3_rd;
        win_nxt[4][4] = pix_data;
    end

    // Each buffer row moves up one line; reads above see the pre-write contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[lb_addr] <= lb1_rd;
            lb1[lb_addr] <= lb2_rd;
            lb2[lb_addr] <= lb3_rd;
            lb3[lb_addr] <= pix_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win_q <= win_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            win_valid <= 1'b0;
            win_data  <= '0;
            win_x     <= '0;
            win_y     <= '0;
            win_last  <= 1'b0;
        end else if (accept) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_LAST) ? 16'd0 : y_cnt + 16'd1;
            end else begin
                x_cnt <= x_cnt + 16'd1;
            end
            win_valid <= emit;
            if (emit) begin
                win_data <= win_nxt;
                win_x    <= x_cnt - 16'd2;
                win_y    <= y_cnt - 16'd2;
                win_last <= (x_cnt == X_LAST) && (y_cnt == Y_LAST);
            end
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule
